bus_wait_ctrl: RTL and testbench

Cycle sequencer for the 6502 memory map. It samples the CPU bus phase (phi2) and the upper address lines, and decodes each bus cycle into one of four regions: RAM, ROM, VIA or ACIA. It then drives a registered active-low chip select for that region. It also holds the CPU RDY line low for a programmable number of wait clocks per region. It sits between the CPU address bus and the peripheral/memory chip-select pins, and replaces a free-running decoder with a sequenced, wait-state-aware one.

---
 rtl/bus_wait_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_bus_wait_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_ctrl.sv
// 6502 bus-cycle sequencer: decodes each phi2 cycle into RAM/ROM/VIA/ACIA,
// drives a registered active-low chip select and stretches RDY by a per-region wait count.
module bus_wait_ctrl #(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi2,
  input  logic [4:0]       addr_hi,
  input  logic             rw,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             err_clr,
  output logic             rdy,
  output logic             cs_ram_n,
  output logic             cs_rom_n,
  output logic             cs_via_n,
  output logic             cs_acia_n,
  output logic             busy,
  output logic [1:0]       region,
  output logic             overrun_err,
  output logic             rom_wr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] REG_RAM  = 2'd0;
  localparam logic [1:0] REG_ROM  = 2'd1;
  localparam logic [1:0] REG_VIA  = 2'd2;
  localparam logic [1:0] REG_ACIA = 2'd3;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_phi2_sync;
  logic                   r_phi2_dly;
  logic                   w_phi2_s;
  logic                   w_rise;
  logic                   w_fall;

  logic [CNT_W-1:0] r_wait_tbl [4];
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_rdy, w_rdy_nxt;
  logic [3:0]       r_cs_n, w_cs_n_nxt;
  logic             r_busy, w_busy_nxt;
  logic [1:0]       r_region, w_region_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_a11, w_a11_nxt;
  logic             r_overrun;
  logic             r_rom_wr;

  logic [1:0]       w_dec_region;
  logic             w_dec_mapped;
  logic             w_rom_wr;
  logic             w_cs_en;
  logic [CNT_W-1:0] w_load_cnt;
  logic             w_ovr_set;
  logic             w_romwr_set;
  logic             w_unused_latched;

  assign w_phi2_s = r_phi2_sync[SYNC_STAGES-1];
  assign w_rise   = w_phi2_s & ~r_phi2_dly;
  assign w_fall   = ~w_phi2_s & r_phi2_dly;

  // Unmapped space reports the VIA code but never asserts a select.
  always_comb begin
    w_dec_mapped = 1'b1;
    w_dec_region = REG_VIA;
    if (addr_hi[4])       w_dec_region = REG_ROM;
    else if (!addr_hi[3]) w_dec_region = REG_RAM;
    else if (addr_hi[2])  w_dec_region = REG_VIA;
    else if (addr_hi[1])  w_dec_region = REG_ACIA;
    else                  w_dec_mapped = 1'b0;
  end

  assign w_rom_wr    = w_dec_mapped && (w_dec_region == REG_ROM) && !rw;
  assign w_cs_en     = w_dec_mapped && !w_rom_wr;
  assign w_load_cnt  = w_cs_en ? r_wait_tbl[w_dec_region] : '0;
  assign w_ovr_set   = (r_state == S_WAIT) && w_fall;
  assign w_romwr_set = (r_state == S_IDLE) && w_rise && w_rom_wr;

  // Latched cycle attributes are kept for visibility but do not steer anything.
  assign w_unused_latched = r_rw ^ r_a11;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_phi2_sync   <= '0;
      r_phi2_dly    <= 1'b0;
      r_wait_tbl[0] <= CNT_W'(0);
      r_wait_tbl[1] <= CNT_W'(1);
      r_wait_tbl[2] <= CNT_W'(2);
      r_wait_tbl[3] <= CNT_W'(3);
      r_cnt         <= '0;
      r_rdy         <= 1'b1;
      r_cs_n        <= 4'b1111;
      r_busy        <= 1'b0;
      r_region      <= REG_RAM;
      r_rw          <= 1'b1;
      r_a11         <= 1'b0;
      r_overrun     <= 1'b0;
      r_rom_wr      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phi2_sync <= {r_phi2_sync[SYNC_STAGES-2:0], phi2};
      r_phi2_dly  <= w_phi2_s;
      if (cfg_we) r_wait_tbl[cfg_sel] <= cfg_data;
      r_cnt       <= w_cnt_nxt;
      r_rdy       <= w_rdy_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_busy      <= w_busy_nxt;
      r_region    <= w_region_nxt;
      r_rw        <= w_rw_nxt;
      r_a11       <= w_a11_nxt;
      r_overrun   <= w_ovr_set | (r_overrun & ~err_clr);
      r_rom_wr    <= w_romwr_set | (r_rom_wr & ~err_clr);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_rise) w_state_nxt = (w_load_cnt == '0) ? S_HOLD : S_WAIT;
      S_WAIT: begin
        if (w_fall)                   w_state_nxt = S_IDLE;
        else if (r_cnt <= CNT_W'(1))  w_state_nxt = S_HOLD;
      end
      S_HOLD: if (w_fall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fall in WAIT takes priority over the count finishing on the same clock.
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_rdy_nxt    = r_rdy;
    w_cs_n_nxt   = r_cs_n;
    w_busy_nxt   = r_busy;
    w_region_nxt = r_region;
    w_rw_nxt     = r_rw;
    w_a11_nxt    = r_a11;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_region_nxt = w_dec_region;
          w_rw_nxt     = rw;
          w_a11_nxt    = addr_hi[0];
          w_busy_nxt   = 1'b1;
          w_cnt_nxt    = w_load_cnt;
          w_rdy_nxt    = (w_load_cnt == '0);
          w_cs_n_nxt   = w_cs_en ? ~(4'b0001 << w_dec_region) : 4'b1111;
        end
      end
      S_WAIT: begin
        if (w_fall) begin
          w_rdy_nxt  = 1'b1;
          w_cs_n_nxt = 4'b1111;
          w_busy_nxt = 1'b0;
          w_cnt_nxt  = '0;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt = '0;
          w_rdy_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (w_fall) begin
          w_cs_n_nxt = 4'b1111;
          w_busy_nxt = 1'b0;
        end
      end
      default: begin
        w_rdy_nxt  = 1'b1;
        w_cs_n_nxt = 4'b1111;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  assign rdy         = r_rdy;
  assign cs_ram_n    = r_cs_n[0];
  assign cs_rom_n    = r_cs_n[1];
  assign cs_via_n    = r_cs_n[2];
  assign cs_acia_n   = r_cs_n[3];
  assign busy        = r_busy;
  assign region      = r_region;
  assign overrun_err = r_overrun;
  assign rom_wr_err  = r_rom_wr;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl: drives phi2 cycles on the falling clk edge
// and samples outputs there, comparing against hand-derived waits and select timing.
module tb_bus_wait_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       phi2 = 1'b0;
  logic [4:0] addr_hi = 5'b00000;
  logic       rw = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [3:0] cfg_data = 4'd0;
  logic       err_clr = 1'b0;
  logic       rdy, cs_ram_n, cs_rom_n, cs_via_n, cs_acia_n, busy;
  logic [1:0] region;
  logic       overrun_err, rom_wr_err;

  int n_checks = 0;
  int n_pass   = 0;

  int         rdy_low, cs_first, cs_rel;
  logic [3:0] cs_seen;
  logic       busy_hi;

  bus_wait_ctrl #(.CNT_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .phi2(phi2), .addr_hi(addr_hi), .rw(rw),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .err_clr(err_clr),
    .rdy(rdy), .cs_ram_n(cs_ram_n), .cs_rom_n(cs_rom_n), .cs_via_n(cs_via_n),
    .cs_acia_n(cs_acia_n), .busy(busy), .region(region),
    .overrun_err(overrun_err), .rom_wr_err(rom_wr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [3:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  function automatic logic [3:0] cs_vec();
    return {cs_acia_n, cs_via_n, cs_rom_n, cs_ram_n};
  endfunction

  // Called on a falling edge. Holds phi2 high for hi samples, then low for 5.
  // Optional cfg write pulsed after sample wr_at (0 = none).
  task automatic bus_cycle(input logic [4:0] a, input logic w, input int hi,
                           input int wr_at, input logic [1:0] wsel, input logic [3:0] wdata,
                           output int o_rdy_low, output logic [3:0] o_cs_seen,
                           output int o_cs_first, output int o_cs_rel, output logic o_busy_hi);
    logic [3:0] cs;
    o_rdy_low = 0; o_cs_seen = 4'b0000; o_cs_first = 0; o_cs_rel = 0;
    addr_hi = a; rw = w; phi2 = 1'b1;
    for (int i = 1; i <= hi; i++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      cs = cs_vec();
      if (!rdy) o_rdy_low++;
      if (cs != 4'hf && o_cs_first == 0) o_cs_first = i;
      o_cs_seen |= ~cs;
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_sel = wsel; cfg_data = wdata;
      end
    end
    o_busy_hi = busy;
    phi2 = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      cs = cs_vec();
      if (!rdy) o_rdy_low++;
      o_cs_seen |= ~cs;
      if (cs == 4'hf && o_cs_rel == 0) o_cs_rel = j;
    end
  endtask

  initial begin
    // Reset held while phi2 toggles
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      phi2 = ~phi2;
    end
    @(negedge clk);
    check("rst_rdy", rdy, 1);
    check("rst_cs", cs_vec(), 4'hf);
    check("rst_busy", busy, 0);
    check("rst_region", region, 0);
    check("rst_errs", {overrun_err, rom_wr_err}, 0);
    phi2 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // RAM cycle with default zero waits
    bus_cycle(5'b00000, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("ram_cs", cs_seen, 4'b0001);
    check("ram_cs_first", cs_first, 3);
    check("ram_rdy_low", rdy_low, 0);
    check("ram_busy", busy_hi, 1);
    check("ram_region", region, 0);

    // ROM read, default one wait
    bus_cycle(5'b10000, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("rom_cs", cs_seen, 4'b0010);
    check("rom_cs_first", cs_first, 3);
    check("rom_rdy_low", rdy_low, 1);
    check("rom_cs_rel", cs_rel, 3);
    check("rom_idle_busy", busy, 0);
    check("rom_region", region, 1);

    // ACIA reprogrammed to 5
    cfg_write(2'd3, 4'd5);
    bus_cycle(5'b01010, 1'b1, 10, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("acia_cs", cs_seen, 4'b1000);
    check("acia_rdy_low", rdy_low, 5);
    check("acia_region", region, 3);

    // Write 0 mid-cycle: this cycle keeps 5, next has 0
    bus_cycle(5'b01010, 1'b1, 10, 4, 2'd3, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("acia_mid_rdy_low", rdy_low, 5);
    bus_cycle(5'b01010, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("acia_next_rdy_low", rdy_low, 0);
    check("acia_next_cs", cs_seen, 4'b1000);

    // Overrun: VIA 15 waits, phi2 high 6 clocks
    cfg_write(2'd2, 4'd15);
    bus_cycle(5'b01100, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("ovr_cs", cs_seen, 4'b0100);
    check("ovr_rdy_low", rdy_low, 6);
    check("ovr_cs_rel", cs_rel, 3);
    check("ovr_err", overrun_err, 1);
    check("ovr_rdy_end", rdy, 1);
    check("ovr_busy_end", busy, 0);
    check("ovr_romerr", rom_wr_err, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovr_clr", overrun_err, 0);

    // ROM write: no select, no wait, sticky error
    bus_cycle(5'b11111, 1'b0, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("romwr_cs", cs_seen, 4'b0000);
    check("romwr_rdy_low", rdy_low, 0);
    check("romwr_err", rom_wr_err, 1);
    check("romwr_busy", busy_hi, 1);
    check("romwr_region", region, 1);

    // Unmapped
    bus_cycle(5'b01000, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("unmap_cs", cs_seen, 4'b0000);
    check("unmap_rdy_low", rdy_low, 0);
    check("unmap_region", region, 2);
    check("unmap_busy", busy_hi, 1);

    // Async reset during WAIT
    cfg_write(2'd0, 4'd7);
    addr_hi = 5'b00000; rw = 1'b1; phi2 = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_pre_cs", cs_vec(), 4'b1110);
    check("arst_pre_rdy", rdy, 0);
    #2;
    rst = 1'b1;
    phi2 = 1'b0;
    #1;
    check("arst_rdy", rdy, 1);
    check("arst_cs", cs_vec(), 4'hf);
    check("arst_busy", busy, 0);
    check("arst_errs", {overrun_err, rom_wr_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bus_cycle(5'b00000, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("arst_ram_rdy_low", rdy_low, 0);
    check("arst_ram_cs", cs_seen, 4'b0001);
    bus_cycle(5'b01010, 1'b1, 6, 0, 2'd0, 4'd0, rdy_low, cs_seen, cs_first, cs_rel, busy_hi);
    check("arst_acia_rdy_low", rdy_low, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
